// File: rtl/med_lane_skid_reg.sv
// Multi-lane skid register: LANES x LANE_W data with per-lane masking, flush and a stall counter.
// Latency: 1 cycle from accepted input to out_valid when empty; sustains 1 beat/cycle.
// Backpressure: two entries (main + skid); in_ready comes from state only, never from out_ready.
module med_lane_skid_reg #(
  parameter int LANES  = 8,
  parameter int LANE_W = 112,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        out_mask,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [LANES-1:0]        mask;
    logic [LANES*LANE_W-1:0] data;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t cap;
  logic   in_fire;
  logic   out_fire;

  // Build the entry to store: masked-off lanes are forced to zero.
  always_comb begin
    cap      = '0;
    cap.mask = in_mask;
    for (int i = 0; i < LANES; i++) begin
      cap.data[i*LANE_W +: LANE_W] = in_mask[i] ? in_data[i*LANE_W +: LANE_W] : '0;
    end
  end

  // Handshake signals; flush/reset block acceptance and suppress the output transfer.
  always_comb begin
    in_ready  = (state != FULL) && !reset && !flush;
    out_valid = (state != EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready && !reset && !flush;
    out_data  = main_q.data;
    out_mask  = main_q.mask;
    case (state)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Entry state machine: main always feeds the output, skid absorbs one beat of back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= cap;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= cap;
          end else if (in_fire) begin
            skid_q <= cap;
            state  <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where an entry is offered but not taken.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
